// File: rtl/ysyx_22040125_exe_div_pkg.sv
// Shared encodings for the RV64M divider: operation codes, FSM states, datapath width.
package ysyx_22040125_exe_div_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040125_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; 64 or 32 iterations.
module ysyx_22040125_div_core
  import ysyx_22040125_exe_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic [XLEN:0]   part, diff;
  logic [5:0]      cnt_q;
  logic            run_q;

  // Partial remainder needs one extra bit: 2*rem + 1 can exceed 64 bits.
  always_comb begin
    part = {rem_q, quo_q[XLEN-1]};
    diff = part - {1'b0, dvsr_q};
    if (diff[XLEN]) begin
      rem_nxt = part[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign done      = run_q && (cnt_q == 6'd0);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      run_q <= 1'b0;
      cnt_q <= 6'd0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= word ? 6'd31 : 6'd63;
    end else if (run_q) begin
      if (cnt_q == 6'd0) run_q <= 1'b0;
      else cnt_q <= cnt_q - 6'd1;
    end
  end

  // Word operands sit in the top half so the same MSB-first shift applies.
  always_ff @(posedge clk) begin
    if (start) begin
      quo_q  <= word ? {dividend[31:0], 32'b0} : dividend;
      rem_q  <= '0;
      dvsr_q <= word ? {32'b0, divisor[31:0]} : divisor;
    end else if (run_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/ysyx_22040125_exe_div.sv
// RV64M divide unit: operand/sign preparation, special-case bypass and handshake FSM.
module ysyx_22040125_exe_div
  import ysyx_22040125_exe_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  state_e          state_q, state_d;
  op_e             op_in;
  logic            sgn_in, rem_in, neg_a, neg_b, div_zero, ovf, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, spec_res;
  logic            is_rem_q, word_q, neg_q_q, neg_r_q;
  logic            core_done;
  logic [XLEN-1:0] core_quo, core_rem;

  function automatic logic [XLEN-1:0] apply_sign(
    input logic is_rem, input logic word, input logic nq, input logic nr,
    input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem);
    logic [XLEN-1:0] res;
    res = is_rem ? (nr ? -rem : rem) : (nq ? -quo : quo);
    return word ? sext32(res[31:0]) : res;
  endfunction

  assign op_in = op_e'(in_op);

  always_comb begin
    sgn_in   = (op_in == OP_DIV) || (op_in == OP_REM);
    rem_in   = (op_in == OP_REM) || (op_in == OP_REMU);
    a_ext    = in_word ? (sgn_in ? sext32(in_src1[31:0]) : {32'b0, in_src1[31:0]}) : in_src1;
    b_ext    = in_word ? (sgn_in ? sext32(in_src2[31:0]) : {32'b0, in_src2[31:0]}) : in_src2;
    neg_a    = sgn_in && a_ext[XLEN-1];
    neg_b    = sgn_in && b_ext[XLEN-1];
    abs_a    = neg_a ? -a_ext : a_ext;
    abs_b    = neg_b ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = sgn_in && (b_ext == '1) &&
               (in_word ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
    special  = div_zero || ovf;
    if (div_zero) spec_res = rem_in ? a_ext : '1;
    else          spec_res = rem_in ? '0 : a_ext;
    if (in_word)  spec_res = sext32(spec_res[31:0]);
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  ysyx_22040125_div_core u_core (
    .clk       (clk),
    .rst       (rst),
    .kill      (flush),
    .start     (accept && !special),
    .word      (in_word),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (core_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      is_rem_q <= rem_in;
      word_q   <= in_word;
      neg_q_q  <= neg_a ^ neg_b;
      neg_r_q  <= neg_a;
    end
  end

  // Result is captured on the final iteration edge and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_rd     <= '0;
    end else if (accept) begin
      out_rd <= in_rd;
      if (special) out_result <= spec_res;
    end else if ((state_q == ST_CALC) && core_done && !flush) begin
      out_result <= apply_sign(is_rem_q, word_q, neg_q_q, neg_r_q, core_quo, core_rem);
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_exe_div.sv
// Directed vector bench for the RV64M divider plus flush/reset/backpressure sequences.
module tb_ysyx_22040125_exe_div;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_word, out_ready;
  logic [1:0]  in_op;
  logic [63:0] in_src1, in_src2;
  logic [4:0]  in_rd;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  ysyx_22040125_exe_div dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_rd = rd;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] rd, input string tag);
    int cyc;
    issue(v.op, v.word, v.a, v.b, rd, tag);
    wait_done(cyc);
    chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, " result"}, out_result, v.exp);
    chk({tag, " rd"}, 64'(out_rd), 64'(rd));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle after take"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int cyc, pulses;
    logic [63:0] held;

    vecs[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 64};
    vecs[1]  = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 64};
    vecs[2]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64};
    vecs[3]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[4]  = '{2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[5]  = '{2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 0};
    vecs[6]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
    vecs[7]  = '{2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'd1, 32};
    vecs[8]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    vecs[9]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0};
    vecs[10] = '{2'b00, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 64};
    vecs[11] = '{2'b10, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64};
    vecs[12] = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFD, 64'd6, 64};
    vecs[13] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[14] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[15] = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64};
    vecs[16] = '{2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32};
    vecs[17] = '{2'b00, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 32};
    vecs[18] = '{2'b10, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 32};
    vecs[19] = '{2'b01, 1'b1, 64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 64'd14, 32};
    vecs[20] = '{2'b11, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'd5, 0};
    vecs[21] = '{2'b01, 1'b1, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[22] = '{2'b11, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0};
    vecs[23] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64};
    vecs[24] = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 64};
    vecs[25] = '{2'b00, 1'b0, 64'd0, 64'd9, 64'd0, 64};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_src1 = '0; in_src2 = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {out_result, 3'b0, out_rd, busy, out_valid}, 64'd0);
    rst = 1'b0;
    chk("ready after reset", 64'({in_ready, busy}), 64'b10);

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i], 5'(i), $sformatf("vec%0d", i));

    // flush in the tenth CALC cycle: no result, next op unaffected
    issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd3, "flush");
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush still calc", 64'({busy, out_valid}), 64'b10);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush to idle", 64'({in_ready, busy, out_valid}), 64'b100);
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("flush no out_valid", 64'(pulses), 64'd0);
    run_vec(vecs[3], 5'd17, "after flush");

    // backpressure: result and tag held, not ready for input
    issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, "hold");
    wait_done(cyc);
    held = 64'hFFFF_FFFF_FFFF_FFFA;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold result c%0d", k), out_result, held);
      chk($sformatf("hold ctrl c%0d", k), 64'({out_rd, in_ready, out_valid, busy}), 64'({5'd9, 3'b011}));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release", 64'({in_ready, out_valid, busy}), 64'b100);

    // flush while DONE discards the result
    issue(2'b01, 1'b0, 64'd5, 64'd0, 5'd4, "flush done");
    chk("flush done valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush done idle", 64'({in_ready, out_valid, busy}), 64'b100);

    // reset mid-CALC
    issue(2'b11, 1'b0, 64'd1000, 64'd33, 5'd21, "rst calc");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst calc outputs", {out_result, 3'b0, out_rd, busy, out_valid}, 64'd0);
    rst = 1'b0;
    chk("rst calc ready", 64'(in_ready), 64'd1);
    run_vec(vecs[0], 5'd30, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
